router_fsm_ctrl: RTL and testbench

- Control block for the 1x3 router input path.
- Sequences the packet register through header, payload, parity and FIFO-full recovery phases.
- Latches the destination address and steers write enables to one of three output FIFOs.
- Runs per-output watchdog timers that issue soft resets when an output FIFO is not drained in time.

---
 rtl/router_fsm_ctrl.sv | 132 +++++++++++++
 tb/tb_router_fsm_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_ctrl.sv
// Input-path controller for the 1x3 router: packet sequencing FSM, destination
// latch, write-enable steering and per-output drain watchdogs.
module router_fsm_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_vld,
  input  logic [1:0] d_in_addr,
  input  logic [2:0] fifo_full_in,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  input  logic       parity_done,
  input  logic       low_pkt_vld,
  output logic       fifo_full,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic [2:0] write_enb,
  output logic       busy,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t             state;
  state_t             next_state;
  logic [1:0]         addr_reg;
  logic [2:0][CW-1:0] wd_cnt;
  logic               write_enb_int;
  logic               in_addr_ok;

  // Address 3 does not exist, so selects by address fall back to 0 for it.
  function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  assign in_addr_ok = pkt_vld && (d_in_addr != 2'b11);

  always_ff @(posedge clk) begin
    if (rst) state <= DECODE_ADDRESS;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst)                                       addr_reg <= 2'd0;
    else if (state == DECODE_ADDRESS && in_addr_ok) addr_reg <= d_in_addr;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DECODE_ADDRESS:
        if (in_addr_ok)
          next_state = pick(fifo_empty, d_in_addr) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (pick(fifo_empty, addr_reg)) next_state = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        next_state = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)     next_state = FIFO_FULL_STATE;
        else if (!pkt_vld) next_state = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)      next_state = DECODE_ADDRESS;
        else if (low_pkt_vld) next_state = LOAD_PARITY;
        else                  next_state = LOAD_DATA;
      LOAD_PARITY:
        next_state = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:
        next_state = DECODE_ADDRESS;
    endcase
    // A watchdog firing on the active output abandons the packet.
    if (state != DECODE_ADDRESS && pick(soft_reset, addr_reg))
      next_state = DECODE_ADDRESS;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        wd_cnt[i]     <= '0;
        soft_reset[i] <= 1'b0;
      end else if (read_enb[i] || fifo_empty[i]) begin
        wd_cnt[i]     <= '0;
        soft_reset[i] <= 1'b0;
      end else if (wd_cnt[i] == WD_LAST) begin
        wd_cnt[i]     <= '0;
        soft_reset[i] <= 1'b1;
      end else begin
        wd_cnt[i]     <= wd_cnt[i] + CW'(1);
        soft_reset[i] <= 1'b0;
      end
    end
  end

  assign detect_addr   = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign write_enb_int = ld_state || laf_state || (state == LOAD_PARITY);
  assign write_enb     = write_enb_int ? (3'b001 << addr_reg) : 3'b000;
  assign busy          = !(detect_addr || ld_state);
  assign fifo_full     = pick(fifo_full_in, addr_reg);
  assign vld_out       = ~fifo_empty;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl: table of per-cycle vectors for the FSM,
// plus hand-written watchdog timing sequences.
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_vld;
  logic [1:0] d_in_addr;
  logic [2:0] fifo_full_in;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       parity_done;
  logic       low_pkt_vld;
  logic       fifo_full;
  logic       detect_addr, lfd_state, ld_state, full_state, laf_state, rst_int_reg;
  logic [2:0] write_enb;
  logic       busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int checks = 0;
  int errors = 0;

  router_fsm_ctrl #(.TIMEOUT(30), .CW(8)) dut (
    .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .d_in_addr(d_in_addr),
    .fifo_full_in(fifo_full_in), .fifo_empty(fifo_empty), .read_enb(read_enb),
    .parity_done(parity_done), .low_pkt_vld(low_pkt_vld), .fifo_full(fifo_full),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb(write_enb), .busy(busy), .vld_out(vld_out), .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  // State flag encoding: {detect, lfd, ld, full, laf, rst_int_reg}
  localparam logic [5:0] DEC  = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] FUL  = 6'b000100;
  localparam logic [5:0] LAF  = 6'b000010;
  localparam logic [5:0] CPE  = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [2:0] E    = 3'b111;

  typedef struct {
    logic       rst, pkt;
    logic [1:0] addr;
    logic [2:0] full_in, empty, rd;
    logic       pdone, low;
    logic [5:0] flags;
    logic [2:0] we;
    logic       busy;
    logic [2:0] sr;
    logic       ff;
  } vec_t;

  vec_t vecs[48];

  function automatic vec_t mk(input logic r, input logic p, input logic [1:0] a,
                              input logic [2:0] fi, input logic [2:0] em,
                              input logic pd, input logic lo,
                              input logic [5:0] fl, input logic [2:0] w,
                              input logic b, input logic ff);
    vec_t v;
    v.rst = r; v.pkt = p; v.addr = a; v.full_in = fi; v.empty = em; v.rd = 3'b000;
    v.pdone = pd; v.low = lo; v.flags = fl; v.we = w; v.busy = b; v.sr = 3'b000;
    v.ff = ff;
    return v;
  endfunction

  function automatic logic [5:0] flags_now();
    return {detect_addr, lfd_state, ld_state, full_state, laf_state, rst_int_reg};
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; pkt_vld = v.pkt; d_in_addr = v.addr; fifo_full_in = v.full_in;
    fifo_empty = v.empty; read_enb = v.rd; parity_done = v.pdone; low_pkt_vld = v.low;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // Packet to addr 1, FIFO1 empty, 3 payload bytes.
    vecs[0]  = mk(1,0,0,0,E,0,0, DEC, 3'b000,0,0);
    vecs[1]  = mk(0,1,1,0,E,0,0, LFD, 3'b000,1,0);
    vecs[2]  = mk(0,1,1,0,E,0,0, LD,  3'b010,0,0);
    vecs[3]  = mk(0,1,1,0,E,0,0, LD,  3'b010,0,0);
    vecs[4]  = mk(0,1,1,0,E,0,0, LD,  3'b010,0,0);
    vecs[5]  = mk(0,0,1,0,E,0,0, NONE,3'b010,1,0);
    vecs[6]  = mk(0,0,1,0,E,0,0, CPE, 3'b000,1,0);
    vecs[7]  = mk(0,0,1,0,E,0,0, DEC, 3'b000,0,0);
    // Addr 2 while FIFO2 still holds data.
    vecs[8]  = mk(0,1,2,0,3'b011,0,0, NONE,3'b000,1,0);
    vecs[9]  = mk(0,1,2,0,3'b011,0,0, NONE,3'b000,1,0);
    vecs[10] = mk(0,1,2,0,3'b011,0,0, NONE,3'b000,1,0);
    vecs[11] = mk(0,1,2,0,3'b011,0,0, NONE,3'b000,1,0);
    vecs[12] = mk(0,1,2,0,E,0,0, LFD, 3'b000,1,0);
    vecs[13] = mk(0,1,2,0,E,0,0, LD,  3'b100,0,0);
    vecs[14] = mk(0,0,2,0,E,0,0, NONE,3'b100,1,0);
    vecs[15] = mk(0,0,2,0,E,0,0, CPE, 3'b000,1,0);
    vecs[16] = mk(0,0,2,0,E,0,0, DEC, 3'b000,0,0);
    // Addr 0, FIFO0 full for 4 cycles, then LAF -> LP via low_pkt_vld.
    vecs[17] = mk(0,1,0,0,E,0,0, LFD, 3'b000,1,0);
    vecs[18] = mk(0,1,0,0,E,0,0, LD,  3'b001,0,0);
    vecs[19] = mk(0,1,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[20] = mk(0,1,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[21] = mk(0,1,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[22] = mk(0,1,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[23] = mk(0,1,0,0,E,0,0, LAF, 3'b001,1,0);
    vecs[24] = mk(0,0,0,0,E,0,1, NONE,3'b001,1,0);
    vecs[25] = mk(0,0,0,0,E,0,0, CPE, 3'b000,1,0);
    vecs[26] = mk(0,0,0,0,E,0,0, DEC, 3'b000,0,0);
    // LAF with parity_done returns straight to decode.
    vecs[27] = mk(0,1,0,0,E,0,0, LFD, 3'b000,1,0);
    vecs[28] = mk(0,1,0,0,E,0,0, LD,  3'b001,0,0);
    vecs[29] = mk(0,1,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[30] = mk(0,1,0,0,E,0,0, LAF, 3'b001,1,0);
    vecs[31] = mk(0,0,0,0,E,1,0, DEC, 3'b000,0,0);
    // Full seen in CPE, then LAF with neither flag goes back to LD.
    vecs[32] = mk(0,1,0,0,E,0,0, LFD, 3'b000,1,0);
    vecs[33] = mk(0,1,0,0,E,0,0, LD,  3'b001,0,0);
    vecs[34] = mk(0,0,0,0,E,0,0, NONE,3'b001,1,0);
    vecs[35] = mk(0,0,0,3'b001,E,0,0, CPE,3'b000,1,1);
    vecs[36] = mk(0,0,0,3'b001,E,0,0, FUL,3'b000,1,1);
    vecs[37] = mk(0,0,0,0,E,0,0, LAF, 3'b001,1,0);
    vecs[38] = mk(0,1,0,0,E,0,0, LD,  3'b001,0,0);
    vecs[39] = mk(0,0,0,0,E,0,0, NONE,3'b001,1,0);
    vecs[40] = mk(0,0,0,0,E,0,0, CPE, 3'b000,1,0);
    vecs[41] = mk(0,0,0,0,E,0,0, DEC, 3'b000,0,0);
    // Invalid address 3: stay in decode, addr_reg stays 0 (fifo_full follows FIFO0).
    vecs[42] = mk(0,1,3,3'b001,E,0,0, DEC,3'b000,0,1);
    vecs[43] = mk(0,0,0,0,E,0,0, DEC, 3'b000,0,0);
    // Reset in the middle of LD.
    vecs[44] = mk(0,1,0,0,E,0,0, LFD, 3'b000,1,0);
    vecs[45] = mk(0,1,0,0,E,0,0, LD,  3'b001,0,0);
    vecs[46] = mk(1,1,0,0,E,0,0, DEC, 3'b000,0,0);
    vecs[47] = mk(0,0,0,0,E,0,0, DEC, 3'b000,0,0);

    for (int i = 0; i < 48; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d flags", i), {2'b00, flags_now()}, {2'b00, vecs[i].flags});
      checkOutput($sformatf("v%0d write_enb", i), {5'b0, write_enb}, {5'b0, vecs[i].we});
      checkOutput($sformatf("v%0d busy", i), {7'b0, busy}, {7'b0, vecs[i].busy});
      checkOutput($sformatf("v%0d soft_reset", i), {5'b0, soft_reset}, {5'b0, vecs[i].sr});
      checkOutput($sformatf("v%0d fifo_full", i), {7'b0, fifo_full}, {7'b0, vecs[i].ff});
      checkOutput($sformatf("v%0d vld_out", i), {5'b0, vld_out}, {5'b0, ~vecs[i].empty});
    end

    // Watchdog on output 1 while waiting for FIFO1 to drain.
    rst = 0; pkt_vld = 1; d_in_addr = 2'd1; fifo_full_in = 0; fifo_empty = 3'b101;
    read_enb = 0; parity_done = 0; low_pkt_vld = 0;
    for (int c = 1; c <= 31; c++) begin
      tick();
      pkt_vld = 0;
      checkOutput($sformatf("wd1 c%0d soft_reset", c), {5'b0, soft_reset},
                  (c == 30) ? 8'h02 : 8'h00);
      checkOutput($sformatf("wd1 c%0d flags", c), {2'b00, flags_now()},
                  {2'b00, (c <= 30) ? NONE : DEC});
    end

    // Reset clears the counter; a read at cycle 20 restarts the count.
    rst = 1;
    tick();
    checkOutput("wd2 rst soft_reset", {5'b0, soft_reset}, 8'h00);
    checkOutput("wd2 rst detect", {7'b0, detect_addr}, 8'h01);
    rst = 0;
    for (int c = 1; c <= 52; c++) begin
      read_enb = (c == 20) ? 3'b010 : 3'b000;
      tick();
      checkOutput($sformatf("wd2 c%0d soft_reset", c), {5'b0, soft_reset},
                  (c == 50) ? 8'h02 : 8'h00);
    end
    checkOutput("wd2 detect", {7'b0, detect_addr}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
